sobol_ctrl: RTL

SOBOL_CTRL -- requirements
Module: sobol_ctrl

---
 rtl/sobol_ctrl_pkg.sv | 15 +
 rtl/sobol_lsz.sv | 21 ++
 rtl/sobol_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/sobol_ctrl_pkg.sv
// Shared definitions for the Sobol sequence controller: word widths and FSM states.
package sobol_ctrl_pkg;

    // Width of the random word, the direction vectors and the step counter.
    localparam int INWD    = 8;
    // Width of a direction-vector index.
    localparam int LOGINWD = $clog2(INWD);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

endpackage

// File: rtl/sobol_lsz.sv
// Least-significant-zero detector: returns the index of the lowest clear bit.
// An all-ones input maps to the top index, the natural last Gray-code step.
module sobol_lsz #(
    parameter int INWD    = 8,
    parameter int LOGINWD = 3
) (
    input  logic [INWD-1:0]    value,
    output logic [LOGINWD-1:0] idx
);

    // Scan from MSB down so the lowest clear bit is the last one written.
    always_comb begin
        idx = LOGINWD'(INWD - 1);
        for (int i = INWD - 1; i >= 0; i--) begin
            if (!value[i]) begin
                idx = LOGINWD'(i);
            end
        end
    end

endmodule

// File: rtl/sobol_ctrl.sv
// Sobol run controller: sequences a fixed number of generator steps, selects the
// direction vector for each step and owns the writable direction-vector table.
module sobol_ctrl
    import sobol_ctrl_pkg::*;
#(
    parameter int INWD    = sobol_ctrl_pkg::INWD,
    parameter int LOGINWD = sobol_ctrl_pkg::LOGINWD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [INWD-1:0]           len,
    input  logic                      dv_wr_en,
    input  logic [LOGINWD-1:0]        dv_wr_idx,
    input  logic [INWD-1:0]           dv_wr_data,
    output logic                      enable,
    output logic [LOGINWD-1:0]        vecIdx,
    output logic [INWD-1:0][INWD-1:0] dirVec,
    output logic                      busy,
    output logic                      done,
    output logic                      dv_wr_err
);

    state_t              state;
    logic [INWD-1:0]     cnt;
    // One bit wider than len so that len==0 can encode a full 2^INWD-step run.
    logic [INWD:0]       remaining;
    logic [LOGINWD-1:0]  lsz_idx;

    sobol_lsz #(
        .INWD    (INWD),
        .LOGINWD (LOGINWD)
    ) u_lsz (
        .value (cnt),
        .idx   (lsz_idx)
    );

    // Run sequencing; enable/busy/done are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            remaining <= '0;
            enable    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dv_wr_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            dv_wr_err <= dv_wr_en && (state == StRun);
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StRun;
                        cnt       <= '0;
                        remaining <= (len == '0) ? {1'b1, {INWD{1'b0}}} : {1'b0, len};
                        enable    <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StRun: begin
                    cnt       <= cnt + INWD'(1);
                    remaining <= remaining - (INWD + 1)'(1);
                    // Abort wins over normal completion and suppresses done.
                    if (stop) begin
                        state  <= StIdle;
                        enable <= 1'b0;
                        busy   <= 1'b0;
                    end else if (remaining == (INWD + 1)'(1)) begin
                        state  <= StDone;
                        enable <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state  <= StIdle;
                    enable <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // Direction-vector table: reset to van der Corput, writable only outside a run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < INWD; i++) begin
                dirVec[i] <= INWD'(1) << (INWD - 1 - i);
            end
        end else if (dv_wr_en && (state != StRun)) begin
            dirVec[dv_wr_idx] <= dv_wr_data;
        end
    end

    // Vector select is only meaningful while stepping; parked at zero otherwise.
    always_comb begin
        vecIdx = enable ? lsz_idx : '0;
    end

endmodule
